// File: rtl/apb_master_requester_if.sv
// Command/response handshake and APB bus bundle for apb_master_requester.
// The master modport is the requester's view; slave is the environment's view.
interface apb_master_requester_if #(
  parameter int PDATA_SIZE = 32
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic                    cmd_write;
  logic [PDATA_SIZE-1:0]   cmd_addr;
  logic [PDATA_SIZE-1:0]   cmd_wdata;
  logic [PDATA_SIZE/8-1:0] cmd_strb;
  logic [2:0]              cmd_prot;

  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [PDATA_SIZE-1:0]   rsp_rdata;
  logic                    rsp_err;
  logic                    rsp_timeout;

  logic                    PSEL;
  logic                    PENABLE;
  logic                    PWRITE;
  logic [PDATA_SIZE-1:0]   PADDR;
  logic [PDATA_SIZE-1:0]   PWDATA;
  logic [PDATA_SIZE/8-1:0] PSTRB;
  logic [2:0]              PPROT;
  logic [PDATA_SIZE-1:0]   PRDATA;
  logic                    PREADY;
  logic                    PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
    input  rsp_ready, PRDATA, PREADY, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
    output rsp_ready, PRDATA, PREADY, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT
  );
endinterface

// File: rtl/apb_master_requester.sv
// APB4 requester: one command at a time, run as SETUP then ACCESS, result on the rsp port.
// Define APB_MASTER_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES wait states.
module apb_master_requester #(
  parameter int PDATA_SIZE     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   PCLK,
  input  logic                   PRESET,
  apb_master_requester_if.master bus
);
  localparam int STRB_W = PDATA_SIZE / 8;

  if (((PDATA_SIZE % 8) != 0) || (TIMEOUT_CYCLES < 1)) begin : g_param_check
    $error("apb_master_requester: illegal PDATA_SIZE or TIMEOUT_CYCLES");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                state_reg;
  logic                  cmd_ready_reg;
  logic                  psel_reg;
  logic                  penable_reg;
  logic                  pwrite_reg;
  logic [PDATA_SIZE-1:0] paddr_reg;
  logic [PDATA_SIZE-1:0] pwdata_reg;
  logic [STRB_W-1:0]     pstrb_reg;
  logic [2:0]            pprot_reg;
  logic                  rsp_valid_reg;
  logic [PDATA_SIZE-1:0] rsp_rdata_reg;
  logic                  rsp_err_reg;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt_reg;
  logic             rsp_timeout_reg;
  logic             timeout_hit;

  // All TIMEOUT_CYCLES wait states already used up; one more PREADY=0 aborts.
  assign timeout_hit     = (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES));
  assign bus.rsp_timeout = rsp_timeout_reg;
`else
  assign bus.rsp_timeout = 1'b0;
`endif

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_reg     <= IDLE;
      cmd_ready_reg <= 1'b1;
      psel_reg      <= 1'b0;
      penable_reg   <= 1'b0;
      pwrite_reg    <= 1'b0;
      paddr_reg     <= '0;
      pwdata_reg    <= '0;
      pstrb_reg     <= '0;
      pprot_reg     <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      wait_cnt_reg    <= '0;
      rsp_timeout_reg <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.cmd_valid) begin
            paddr_reg     <= bus.cmd_addr;
            pwrite_reg    <= bus.cmd_write;
            pprot_reg     <= bus.cmd_prot;
            // Reads leave PWDATA at its last value and drive no strobes.
            if (bus.cmd_write) begin
              pwdata_reg <= bus.cmd_wdata;
              pstrb_reg  <= bus.cmd_strb;
            end else begin
              pstrb_reg  <= '0;
            end
            psel_reg      <= 1'b1;
            cmd_ready_reg <= 1'b0;
            state_reg     <= SETUP;
`ifdef APB_MASTER_TIMEOUT_EN
            wait_cnt_reg  <= '0;
`endif
          end
        end
        SETUP: begin
          penable_reg <= 1'b1;
          state_reg   <= ACCESS;
        end
        ACCESS: begin
          if (bus.PREADY) begin
            rsp_rdata_reg <= pwrite_reg ? '0 : bus.PRDATA;
            rsp_err_reg   <= bus.PSLVERR;
            psel_reg      <= 1'b0;
            penable_reg   <= 1'b0;
            rsp_valid_reg <= 1'b1;
            state_reg     <= RESP;
`ifdef APB_MASTER_TIMEOUT_EN
            rsp_timeout_reg <= 1'b0;
          end else if (timeout_hit) begin
            rsp_rdata_reg   <= '0;
            rsp_err_reg     <= 1'b1;
            rsp_timeout_reg <= 1'b1;
            psel_reg        <= 1'b0;
            penable_reg     <= 1'b0;
            rsp_valid_reg   <= 1'b1;
            state_reg       <= RESP;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
`endif
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            cmd_ready_reg <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_reg;
  assign bus.PSEL      = psel_reg;
  assign bus.PENABLE   = penable_reg;
  assign bus.PWRITE    = pwrite_reg;
  assign bus.PADDR     = paddr_reg;
  assign bus.PWDATA    = pwdata_reg;
  assign bus.PSTRB     = pstrb_reg;
  assign bus.PPROT     = pprot_reg;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_rdata = rsp_rdata_reg;
  assign bus.rsp_err   = rsp_err_reg;
endmodule

// File: tb/tb_apb_master_requester.sv
// Bench for apb_master_requester: directed scenarios plus random transfers against
// an expected-result model derived from each command and the slave's planned behaviour.
module tb_apb_master_requester;
  localparam int DW  = 32;
  localparam int TMO = 4;

  logic pclk = 1'b0;
  logic preset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic [DW-1:0] last_wdata;

  apb_master_requester_if #(.PDATA_SIZE(DW)) bus ();

  apb_master_requester #(.PDATA_SIZE(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .PCLK   (pclk),
    .PRESET (preset),
    .bus    (bus)
  );

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Runs one command; called at a negedge with the DUT idle, returns at a negedge.
  task automatic run_xfer(input bit wr, input logic [DW-1:0] addr, input logic [DW-1:0] wdata,
                          input logic [3:0] strb, input logic [2:0] prot, input int waits,
                          input logic [DW-1:0] rdata, input bit slverr, input int hold);
    int t0, n_acc, exp_acc;
    bit abort;
    logic [DW-1:0] exp_rdata;
    exp_acc = waits + 1;
    abort   = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
    if (waits > TMO) begin
      exp_acc = TMO + 1;
      abort   = 1'b1;
    end
`endif
    exp_rdata = (abort || wr) ? '0 : rdata;

    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    bus.cmd_strb  = strb;
    bus.cmd_prot  = prot;
    check("idle_cmd_ready", bus.cmd_ready, 1);
    t0 = cyc;
    @(negedge pclk);
    bus.cmd_valid = 1'b0;
    check("setup_psel_penable", {bus.PSEL, bus.PENABLE}, 2'b10);
    check("setup_cmd_ready", bus.cmd_ready, 0);
    check("setup_paddr", bus.PADDR, addr);
    check("setup_pwrite", bus.PWRITE, wr);
    check("setup_pstrb", bus.PSTRB, wr ? strb : 4'h0);
    check("setup_pwdata", bus.PWDATA, wr ? wdata : last_wdata);
    check("setup_pprot", bus.PPROT, prot);
    if (wr) last_wdata = wdata;
    bus.PREADY  = 1'($urandom);
    bus.PSLVERR = 1'($urandom);
    @(negedge pclk);

    n_acc = 0;
    while (bus.PSEL && bus.PENABLE && n_acc < 64) begin
      n_acc++;
      check("access_paddr", bus.PADDR, addr);
      check("access_pwdata", bus.PWDATA, last_wdata);
      check("access_rsp_valid", bus.rsp_valid, 0);
      bus.PREADY  = (n_acc == waits + 1);
      bus.PRDATA  = bus.PREADY ? rdata : $urandom;
      bus.PSLVERR = bus.PREADY ? slverr : 1'($urandom);
      @(negedge pclk);
    end
    bus.PREADY  = 1'b0;
    bus.PSLVERR = 1'b0;
    check("access_cycles", n_acc, exp_acc);
    check("rsp_latency", cyc - t0, exp_acc + 2);
    check("rsp_valid", bus.rsp_valid, 1);
    check("rsp_psel_penable", {bus.PSEL, bus.PENABLE}, 2'b00);
    check("rsp_rdata", bus.rsp_rdata, exp_rdata);
    check("rsp_err", bus.rsp_err, abort | slverr);
    check("rsp_timeout", bus.rsp_timeout, abort);

    for (int i = 0; i < hold; i++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'($urandom);
      bus.cmd_addr  = $urandom;
      bus.cmd_wdata = $urandom;
      bus.cmd_strb  = 4'($urandom);
      @(negedge pclk);
      check("hold_rsp_valid", bus.rsp_valid, 1);
      check("hold_rsp_rdata", bus.rsp_rdata, exp_rdata);
      check("hold_rsp_err", bus.rsp_err, abort | slverr);
      check("hold_cmd_ready", bus.cmd_ready, 0);
      check("hold_psel", bus.PSEL, 0);
      check("hold_paddr", bus.PADDR, addr);
    end
    bus.rsp_ready = 1'b1;
    @(negedge pclk);
    bus.rsp_ready = 1'b0;
    if (hold == 0) bus.cmd_valid = 1'b0;
    check("post_rsp_valid", bus.rsp_valid, 0);
    check("post_cmd_ready", bus.cmd_ready, 1);
  endtask

  initial begin
    preset        = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.cmd_strb  = '0;
    bus.cmd_prot  = '0;
    bus.rsp_ready = 1'b0;
    bus.PRDATA    = '0;
    bus.PREADY    = 1'b0;
    bus.PSLVERR   = 1'b0;
    last_wdata    = '0;
    repeat (3) @(negedge pclk);
    check("reset_cmd_ready", bus.cmd_ready, 1);
    check("reset_psel_penable", {bus.PSEL, bus.PENABLE}, 2'b00);
    check("reset_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_timeout}, 3'b000);
    check("reset_rsp_rdata", bus.rsp_rdata, 0);
    check("reset_apb_fields", {bus.PADDR, bus.PWDATA, bus.PSTRB, bus.PPROT, bus.PWRITE}, 0);
    preset = 1'b0;
    @(negedge pclk);

    run_xfer(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3'd0, 0, 32'h0, 1'b0, 0);
    run_xfer(1'b0, 32'h0000_0020, 32'h0, 4'hF, 3'd0, 3, 32'h1234_5678, 1'b0, 0);
    run_xfer(1'b1, 32'h0000_0030, 32'h0000_55AA, 4'h3, 3'd2, 0, 32'h0, 1'b1, 0);
    run_xfer(1'b0, 32'h0000_0040, 32'h0, 4'h0, 3'd1, 1, 32'hCAFE_F00D, 1'b0, 5);
    run_xfer(1'b1, 32'h0000_0044, 32'h0BAD_F00D, 4'h5, 3'd7, 0, 32'h0, 1'b0, 0);

    // Reset during ACCESS: transfer dropped, no response ever appears.
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 32'h0000_0060;
    bus.cmd_wdata = 32'h7777_1111;
    @(negedge pclk);
    bus.cmd_valid = 1'b0;
    @(negedge pclk);
    @(negedge pclk);
    check("prereset_penable", bus.PENABLE, 1);
    preset = 1'b1;
    @(negedge pclk);
    preset = 1'b0;
    last_wdata = '0;
    check("midreset_psel_penable", {bus.PSEL, bus.PENABLE}, 2'b00);
    check("midreset_cmd_ready", bus.cmd_ready, 1);
    check("midreset_rsp_valid", bus.rsp_valid, 0);
    bus.PREADY = 1'b1;
    repeat (3) begin
      @(negedge pclk);
      check("after_reset_rsp_valid", bus.rsp_valid, 0);
      check("after_reset_psel", bus.PSEL, 0);
    end
    bus.PREADY = 1'b0;

    // Wait-state boundary: one past the limit aborts when enabled, exactly at it completes.
    run_xfer(1'b0, 32'h0000_0050, 32'h0, 4'h0, 3'd0, TMO + 6, 32'hA5A5_0001, 1'b0, 0);
    run_xfer(1'b0, 32'h0000_0054, 32'h0, 4'h0, 3'd0, TMO, 32'hA5A5_0002, 1'b0, 0);
    run_xfer(1'b1, 32'h0000_0058, 32'h1111_2222, 4'hC, 3'd0, TMO + 1, 32'h0, 1'b0, 0);

    for (int n = 0; n < 40; n++) begin
      run_xfer(1'($urandom), $urandom, $urandom, 4'($urandom), 3'($urandom),
               int'($urandom_range(0, 7)), $urandom, 1'($urandom),
               (n == 39) ? 0 : int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
